// File: rtl/avalon_byte_bridge.sv
// avalon_byte_bridge: Avalon-MM slave bridging a CPU to a valid/ready byte stream.
// Holds a TX FIFO (CPU -> stream) and an RX FIFO (stream -> CPU), programmable
// interrupt thresholds, a sticky write-overflow flag and a level status register.
// Optional feature macro: AVB_BRIDGE_LOOPBACK_EN adds CONTROL[4] lpbk, which routes
// the TX head straight into RX and silences both stream handshakes.
module avalon_byte_bridge #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned TX_DEPTH_LOG2 = 6,
    parameter int unsigned RX_DEPTH_LOG2 = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        av_address,
    input  logic              av_chipselect,
    input  logic              av_read_n,
    input  logic              av_write_n,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic              av_irq,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int unsigned TX_PW    = TX_DEPTH_LOG2 + 1;
    localparam int unsigned RX_PW    = RX_DEPTH_LOG2 + 1;
    localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_CONTROL = 2'd1,
        REG_THRESH  = 2'd2,
        REG_STATUS  = 2'd3
    } reg_addr_e;

    // FIFO storage and wrap-bit pointers
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TX_PW-1:0]  tx_wr, tx_rd, tx_wr_nxt, tx_rd_nxt;
    logic [RX_PW-1:0]  rx_wr, rx_rd, rx_wr_nxt, rx_rd_nxt;
    logic [TX_PW-1:0]  tx_count, tx_free, tx_count_nxt;
    logic [RX_PW-1:0]  rx_count, rx_count_nxt;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head, rx_head, rx_push_data;

    // Control / status state
    logic              ien_rx, ien_tx, woverflow;
    logic [15:0]       rx_thresh, tx_thresh;
    logic              rx_pend, tx_pend;

    // Access decode
    reg_addr_e         addr;
    logic              accept, rd_acc, wr_acc;
    logic              tx_push, tx_pop, rx_push, rx_pop, lb_move;
    logic              lpbk, lpbk_nxt;
    logic [31:0]       rdata_c;

    assign addr   = reg_addr_e'(av_address);
    assign accept = av_chipselect & (~av_read_n | ~av_write_n) & av_waitrequest;
    assign rd_acc = accept & ~av_read_n;
    assign wr_acc = accept & ~av_write_n & av_read_n;

    assign tx_count = tx_wr - tx_rd;
    assign rx_count = rx_wr - rx_rd;
    assign tx_full  = (tx_count == TX_PW'(TX_DEPTH));
    assign rx_full  = (rx_count == RX_PW'(RX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_empty = (rx_count == '0);
    assign tx_free  = TX_PW'(TX_DEPTH) - tx_count;
    assign tx_head  = tx_mem[tx_rd[TX_DEPTH_LOG2-1:0]];
    assign rx_head  = rx_mem[rx_rd[RX_DEPTH_LOG2-1:0]];
    assign tx_data  = tx_head;

`ifdef AVB_BRIDGE_LOOPBACK_EN
    assign lpbk_nxt = (wr_acc && addr == REG_CONTROL) ? av_writedata[4] : lpbk;
    assign lb_move  = lpbk & ~tx_empty & ~rx_full;

    // Loopback enable register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lpbk <= 1'b0;
        else        lpbk <= lpbk_nxt;
    end
`else
    logic unused_lpbk_bit;
    assign unused_lpbk_bit = av_writedata[4];
    assign lpbk     = 1'b0;
    assign lpbk_nxt = 1'b0;
    assign lb_move  = 1'b0;
`endif

    // Push/pop strobes; full/empty are judged on start-of-cycle counts
    assign tx_push      = wr_acc & (addr == REG_DATA) & ~tx_full;
    assign tx_pop       = (tx_valid & tx_ready) | lb_move;
    assign rx_pop       = rd_acc & (addr == REG_DATA) & ~rx_empty;
    assign rx_push      = (rx_valid & rx_ready) | lb_move;
    assign rx_push_data = lb_move ? tx_head : rx_data;

    assign tx_wr_nxt    = tx_wr + TX_PW'(tx_push);
    assign tx_rd_nxt    = tx_rd + TX_PW'(tx_pop);
    assign rx_wr_nxt    = rx_wr + RX_PW'(rx_push);
    assign rx_rd_nxt    = rx_rd + RX_PW'(rx_pop);
    assign tx_count_nxt = tx_wr_nxt - tx_rd_nxt;
    assign rx_count_nxt = rx_wr_nxt - rx_rd_nxt;

    assign rx_pend = (16'(rx_count) >= rx_thresh);
    assign tx_pend = (16'(tx_free) >= tx_thresh);

    // Read data mux, sampled into av_readdata on read accept
    always_comb begin
        rdata_c = '0;
        case (addr)
            REG_DATA: begin
                if (!rx_empty) begin
                    rdata_c[DATA_W-1:0] = rx_head;
                    rdata_c[15]         = 1'b1;
                end
                rdata_c[31:16] = 16'(rx_count);
            end
            REG_CONTROL: begin
                rdata_c[0]     = ien_rx;
                rdata_c[1]     = ien_tx;
                rdata_c[4]     = lpbk;
                rdata_c[8]     = rx_pend;
                rdata_c[9]     = tx_pend;
                rdata_c[10]    = woverflow;
                rdata_c[31:16] = 16'(tx_free);
            end
            REG_THRESH: rdata_c = {tx_thresh, rx_thresh};
            REG_STATUS: rdata_c = {16'(tx_count), 16'(rx_count)};
            default:    rdata_c = '0;
        endcase
    end

    // FIFO memories carry no reset; pointers alone define their contents
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[TX_DEPTH_LOG2-1:0]] <= av_writedata[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wr[RX_DEPTH_LOG2-1:0]] <= rx_push_data;
    end

    // Pointers, handshake, registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr          <= '0;
            tx_rd          <= '0;
            rx_wr          <= '0;
            rx_rd          <= '0;
            av_waitrequest <= 1'b1;
            av_readdata    <= '0;
            av_irq         <= 1'b0;
            tx_valid       <= 1'b0;
            rx_ready       <= 1'b0;
            ien_rx         <= 1'b0;
            ien_tx         <= 1'b0;
            woverflow      <= 1'b0;
            rx_thresh      <= 16'd1;
            tx_thresh      <= 16'(TX_DEPTH / 2);
        end else begin
            tx_wr          <= tx_wr_nxt;
            tx_rd          <= tx_rd_nxt;
            rx_wr          <= rx_wr_nxt;
            rx_rd          <= rx_rd_nxt;
            av_waitrequest <= ~accept;
            if (rd_acc) av_readdata <= rdata_c;
            av_irq   <= (ien_rx & rx_pend) | (ien_tx & tx_pend);
            tx_valid <= (tx_count_nxt != '0) & ~lpbk_nxt;
            rx_ready <= (rx_count_nxt != RX_PW'(RX_DEPTH)) & ~lpbk_nxt;

            if (wr_acc && addr == REG_DATA && tx_full) begin
                woverflow <= 1'b1;
            end else if (wr_acc && addr == REG_CONTROL && av_writedata[10]) begin
                woverflow <= 1'b0;
            end

            if (wr_acc && addr == REG_CONTROL) begin
                ien_rx <= av_writedata[0];
                ien_tx <= av_writedata[1];
            end

            if (wr_acc && addr == REG_THRESH) begin
                rx_thresh <= av_writedata[15:0];
                tx_thresh <= av_writedata[31:16];
            end
        end
    end

endmodule
